// File: rtl/cpu_pkg.sv
// cpu_pkg -- definitions shared by the RISC core blocks.
//   * 4-bit opcode encodings seen by the program sequencer
//   * 2-bit sequencer state encoding (RUN / HALT / FAULT)
package cpu_pkg;

  localparam logic [3:0] OP_HLT  = 4'b0000;
  localparam logic [3:0] OP_SKZ  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_LDA  = 4'b0101;
  localparam logic [3:0] OP_STO  = 4'b0110;
  localparam logic [3:0] OP_JMP  = 4'b0111;
  localparam logic [3:0] OP_CALL = 4'b1000;
  localparam logic [3:0] OP_RET  = 4'b1001;
  localparam logic [3:0] OP_JZ   = 4'b1010;
  localparam logic [3:0] OP_JNZ  = 4'b1011;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_HALT  = 2'b01,
    ST_FAULT = 2'b10
  } seq_state_t;

endpackage

// File: rtl/ret_stack.sv
// ret_stack -- parametrised LIFO holding return addresses.
// Ports:
//   clock, reset  rising-edge clock, asynchronous active-high reset
//   push          write wdata above the current top (ignored when full)
//   pop           discard the top entry (ignored when empty)
//   clear         drop every entry (level -> 0); wins over push/pop
//   wdata         address to push
//   top           most recently pushed entry (undefined content when empty)
//   level         number of valid entries, 0..STACK_DEPTH
//   full, empty   level == STACK_DEPTH / level == 0
module ret_stack
  import cpu_pkg::*;
#(
  parameter int ADDR_W      = 5,
  parameter int STACK_DEPTH = 4,
  parameter int LEVEL_W     = $clog2(STACK_DEPTH) + 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic               clear,
  input  logic [ADDR_W-1:0]  wdata,
  output logic [ADDR_W-1:0]  top,
  output logic [LEVEL_W-1:0] level,
  output logic               full,
  output logic               empty
);

  localparam int IDX_W = LEVEL_W - 1;

  logic [ADDR_W-1:0] mem [STACK_DEPTH];
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  top_idx;

  // With STACK_DEPTH a power of two, the low bits of level index the next free
  // slot and (level-1) wraps onto the top entry.
  assign wr_idx  = level[IDX_W-1:0];
  assign top_idx = level[IDX_W-1:0] - IDX_W'(1);

  assign full  = (level == LEVEL_W'(STACK_DEPTH));
  assign empty = (level == '0);
  assign top   = mem[top_idx];

  // NOTE: the entries are reset along with the level so a stale return address
  // can never be observed after reset; at this tiny depth that costs nothing.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      level <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      level <= '0;
    end else if (push && !full) begin
      mem[wr_idx] <= wdata;
      level       <= level + LEVEL_W'(1);
    end else if (pop && !empty) begin
      level <= level - LEVEL_W'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer -- program sequencer for the RISC core: next-pc selection,
// call/return stack, conditional jumps and a RUN/HALT/FAULT state machine.
// Ports:
//   clock, reset  rising-edge clock, asynchronous active-high reset
//   en            advance strobe; nothing changes while en=0
//   opcode        decoded opcode (cpu_pkg encodings)
//   addr          operand / jump target from the instruction
//   zero          accumulator-is-zero flag
//   resume        leave HALT (pc+1) or FAULT (pc kept, stack emptied)
//   pc            registered program counter
//   address       registered operand address (loaded each en cycle in RUN)
//   state         00 RUN, 01 HALT, 10 FAULT
//   stack_level   number of valid return addresses
//   fault_ovf     sticky: CALL with a full stack
//   fault_unf     sticky: RET with an empty stack
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int ADDR_W      = 5,
  parameter int STACK_DEPTH = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           en,
  input  logic [3:0]                     opcode,
  input  logic [ADDR_W-1:0]              addr,
  input  logic                           zero,
  input  logic                           resume,
  output logic [ADDR_W-1:0]              pc,
  output logic [ADDR_W-1:0]              address,
  output logic [1:0]                     state,
  output logic [$clog2(STACK_DEPTH):0]   stack_level,
  output logic                           fault_ovf,
  output logic                           fault_unf
);

  localparam int LEVEL_W = $clog2(STACK_DEPTH) + 1;

  seq_state_t        state_q;
  logic [ADDR_W-1:0] pc_plus1;
  logic [ADDR_W-1:0] stack_top;
  logic              stack_full;
  logic              stack_empty;
  logic              do_push;
  logic              do_pop;
  logic              do_clear;
  logic              in_run;

  assign pc_plus1 = pc + ADDR_W'(1);   // wraps modulo 2^ADDR_W
  assign in_run   = en && (state_q == ST_RUN);
  assign state    = state_q;

  // Stack operations are only issued when they can succeed; a blocked CALL/RET
  // faults instead and leaves the stack untouched.
  assign do_push  = in_run && (opcode == OP_CALL) && !stack_full;
  assign do_pop   = in_run && (opcode == OP_RET)  && !stack_empty;
  assign do_clear = en && (state_q == ST_FAULT) && resume;

  ret_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH),
    .LEVEL_W     (LEVEL_W)
  ) u_stack (
    .clock (clock),
    .reset (reset),
    .push  (do_push),
    .pop   (do_pop),
    .clear (do_clear),
    .wdata (pc_plus1),
    .top   (stack_top),
    .level (stack_level),
    .full  (stack_full),
    .empty (stack_empty)
  );

  // NOTE: all state here is assigned with <= so every register samples the
  // pre-edge values of the others; blocking assignments would make the result
  // depend on statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc        <= '0;
      address   <= '0;
      state_q   <= ST_RUN;
      fault_ovf <= 1'b0;
      fault_unf <= 1'b0;
    end else if (en) begin
      case (state_q)
        ST_RUN: begin
          address <= addr;
          case (opcode)
            OP_HLT:  state_q <= ST_HALT;
            OP_SKZ:  pc <= zero ? pc + ADDR_W'(2) : pc_plus1;
            OP_JMP:  pc <= addr;
            OP_JZ:   pc <= zero ? addr : pc_plus1;
            OP_JNZ:  pc <= zero ? pc_plus1 : addr;
            OP_CALL: begin
              if (stack_full) begin
                fault_ovf <= 1'b1;
                state_q   <= ST_FAULT;
              end else begin
                pc <= addr;
              end
            end
            OP_RET: begin
              if (stack_empty) begin
                fault_unf <= 1'b1;
                state_q   <= ST_FAULT;
              end else begin
                pc <= stack_top;
              end
            end
            default: pc <= pc_plus1;
          endcase
        end
        ST_HALT: begin
          if (resume) begin
            state_q <= ST_RUN;
            pc      <= pc_plus1;  // continue after the HLT
          end
        end
        ST_FAULT: begin
          // pc is kept so the faulting instruction re-executes.
          if (resume) begin
            state_q   <= ST_RUN;
            fault_ovf <= 1'b0;
            fault_unf <= 1'b0;
          end
        end
        default: state_q <= ST_RUN;  // unused encoding 11: recover to RUN
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer -- directed self-checking bench for pc_sequencer
// (ADDR_W=5, STACK_DEPTH=4).
module tb_pc_sequencer;
  import cpu_pkg::*;

  localparam int ADDR_W      = 5;
  localparam int STACK_DEPTH = 4;

  logic              clock;
  logic              reset;
  logic              en;
  logic [3:0]        opcode;
  logic [ADDR_W-1:0] addr;
  logic              zero;
  logic              resume;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] address;
  logic [1:0]        state;
  logic [2:0]        stack_level;
  logic              fault_ovf;
  logic              fault_unf;

  int checks = 0;
  int errors = 0;

  pc_sequencer #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .en          (en),
    .opcode      (opcode),
    .addr        (addr),
    .zero        (zero),
    .resume      (resume),
    .pc          (pc),
    .address     (address),
    .state       (state),
    .stack_level (stack_level),
    .fault_ovf   (fault_ovf),
    .fault_unf   (fault_unf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One en cycle: inputs are set #1 after an edge, applied on the next rising
  // edge, and outputs are read #1 after that edge.
  task automatic step(input logic [3:0] op, input int a, input logic z, input logic r);
    en     = 1'b1;
    opcode = op;
    addr   = ADDR_W'(a);
    zero   = z;
    resume = r;
    @(posedge clock);
    #1;
    en     = 1'b0;
    resume = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    reset  = 1'b1;
    en     = 1'b0;
    opcode = OP_ADD;
    addr   = '0;
    zero   = 1'b0;
    resume = 1'b0;
    idle(2);
    check("rst_pc", pc, 0);
    check("rst_address", address, 0);
    check("rst_state", state, 0);
    check("rst_level", stack_level, 0);
    check("rst_ovf", fault_ovf, 0);
    check("rst_unf", fault_unf, 0);
    reset = 1'b0;
    idle(1);

    // 1. default advance: 33 cycles count 1..31, wrap to 0, then 1
    for (int i = 1; i <= 33; i++) begin
      step(OP_ADD, i + 3, 1'b0, 1'b0);
      check("count_pc", pc, i % 32);
      check("count_state", state, 0);
    end
    check("count_address", address, (33 + 3) % 32);

    // en=0 holds everything
    idle(3);
    check("hold_pc", pc, 1);
    check("hold_address", address, 4);

    // 2. SKZ and conditional jumps
    step(OP_JMP, 5, 1'b0, 1'b0);  check("jmp_pc", pc, 5);
    step(OP_SKZ, 0, 1'b1, 1'b0);  check("skz_taken", pc, 7);
    step(OP_SKZ, 0, 1'b0, 1'b0);  check("skz_not", pc, 8);
    step(OP_JMP, 30, 1'b0, 1'b0);
    step(OP_SKZ, 0, 1'b1, 1'b0);  check("skz_wrap30", pc, 0);
    step(OP_JMP, 31, 1'b0, 1'b0);
    step(OP_SKZ, 0, 1'b1, 1'b0);  check("skz_wrap31", pc, 1);
    step(OP_JZ, 12, 1'b1, 1'b0);  check("jz_taken", pc, 12);
    step(OP_JZ, 20, 1'b0, 1'b0);  check("jz_not", pc, 13);
    step(OP_JNZ, 3, 1'b0, 1'b0);  check("jnz_taken", pc, 3);
    step(OP_JNZ, 9, 1'b1, 1'b0);  check("jnz_not", pc, 4);

    // 3. nested calls from pc=3
    step(OP_JMP, 3, 1'b0, 1'b0);
    step(OP_CALL, 10, 1'b0, 1'b0); check("call1_pc", pc, 10); check("call1_lvl", stack_level, 1);
    step(OP_CALL, 20, 1'b0, 1'b0); check("call2_pc", pc, 20); check("call2_lvl", stack_level, 2);
    step(OP_RET, 0, 1'b0, 1'b0);   check("ret1_pc", pc, 11);  check("ret1_lvl", stack_level, 1);
    step(OP_RET, 0, 1'b0, 1'b0);   check("ret2_pc", pc, 4);   check("ret2_lvl", stack_level, 0);

    // CALL at the top address pushes 0
    step(OP_JMP, 31, 1'b0, 1'b0);
    step(OP_CALL, 2, 1'b0, 1'b0);  check("calltop_pc", pc, 2);
    step(OP_RET, 0, 1'b0, 1'b0);   check("rettop_pc", pc, 0);

    // 4. overflow: five CALLs to 6
    for (int i = 1; i <= 4; i++) begin
      step(OP_CALL, 6, 1'b0, 1'b0);
      check("ovf_fill_lvl", stack_level, i);
    end
    check("ovf_fill_state", state, 0);
    step(OP_CALL, 6, 1'b0, 1'b0);
    check("ovf_flag", fault_ovf, 1);
    check("ovf_state", state, 2);
    check("ovf_pc", pc, 6);
    check("ovf_lvl", stack_level, 4);
    step(OP_JMP, 15, 1'b0, 1'b0);   // ignored in FAULT
    check("fault_hold_pc", pc, 6);
    check("fault_hold_address", address, 6);
    check("fault_hold_flag", fault_ovf, 1);
    step(OP_ADD, 0, 1'b0, 1'b1);    // resume
    check("ovf_res_state", state, 0);
    check("ovf_res_lvl", stack_level, 0);
    check("ovf_res_ovf", fault_ovf, 0);
    check("ovf_res_unf", fault_unf, 0);
    check("ovf_res_pc", pc, 6);

    // 5. halt, resume, then underflow
    step(OP_JMP, 9, 1'b0, 1'b0);
    step(OP_HLT, 0, 1'b0, 1'b0);
    check("hlt_state", state, 1);
    check("hlt_pc", pc, 9);
    for (int i = 0; i < 3; i++) begin
      step(OP_JMP, 25, 1'b1, 1'b0);
      check("hlt_hold_pc", pc, 9);
      check("hlt_hold_state", state, 1);
    end
    check("hlt_hold_address", address, 0);
    step(OP_ADD, 0, 1'b0, 1'b1);
    check("hlt_res_pc", pc, 10);
    check("hlt_res_state", state, 0);
    step(OP_ADD, 0, 1'b0, 1'b1);    // resume in RUN has no effect
    check("run_resume_pc", pc, 11);
    check("run_resume_state", state, 0);
    step(OP_RET, 0, 1'b0, 1'b0);
    check("unf_flag", fault_unf, 1);
    check("unf_state", state, 2);
    check("unf_pc", pc, 11);
    check("unf_ovf", fault_ovf, 0);
    step(OP_ADD, 0, 1'b0, 1'b1);
    check("unf_res_state", state, 0);
    check("unf_res_flag", fault_unf, 0);
    check("unf_res_pc", pc, 11);

    // 6. asynchronous reset with two entries on the stack, pc=17
    step(OP_JMP, 15, 1'b0, 1'b0);
    step(OP_CALL, 30, 1'b0, 1'b0);
    step(OP_CALL, 17, 1'b0, 1'b0);
    check("pre_rst_pc", pc, 17);
    check("pre_rst_lvl", stack_level, 2);
    #2;
    reset = 1'b1;
    #1;
    check("async_pc", pc, 0);
    check("async_lvl", stack_level, 0);
    check("async_state", state, 0);
    check("async_address", address, 0);
    #1;
    reset = 1'b0;
    idle(3);
    check("post_rst_pc", pc, 0);
    check("post_rst_lvl", stack_level, 0);
    check("post_rst_state", state, 0);
    // stack emptied by reset: a RET now underflows
    step(OP_RET, 0, 1'b0, 1'b0);
    check("post_rst_unf", fault_unf, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised next-generation program sequencer for the RISC CPU core. It replaces the fixed 5-bit program counter and adds:
- configurable address width;
- a hardware call/return stack of configurable depth;
- conditional jumps;
- an explicit RUN/HALT/FAULT state machine with resume.

It sits between the instruction decoder (opcode, operand address, zero flag) and the instruction/operand memory address mux.

Parameters:
ADDR_W, 5, width of program counter, operand address and stack entries
STACK_DEPTH, 4, number of return-address entries (power of two, 2..16)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
en  input  1  sequencer advance strobe; all state updates are qualified by en=1
opcode  input  4  decoded opcode (encoding in the shared package)
addr  input  ADDR_W  operand/target address from the instruction
zero  input  1  accumulator-is-zero flag, valid when en=1
resume  input  1  leaves HALT or FAULT on the next en cycle
pc  output  ADDR_W  current program counter (registered)
address  output  ADDR_W  registered operand address
state  output  2  00 RUN, 01 HALT, 10 FAULT
stack_level  output  clog2(STACK_DEPTH)+1  number of valid stack entries
fault_ovf  output  1  sticky: CALL issued with stack full
fault_unf  output  1  sticky: RET issued with stack empty

Behaviour:
- Reset (asynchronous, active-high) sets pc=0, address=0, state=RUN, stack_level=0, both fault flags=0, and all stack entries to 0.
- Updates occur only on a rising clock edge with en=1. With en=0 everything holds.
- Latency: a new pc is visible one cycle after the en edge.
- Opcodes in RUN. All arithmetic is modulo 2^ADDR_W (wrap, no saturation).
  - HLT 0000: pc holds; state goes to HALT.
  - SKZ 0001: pc+2 if zero=1, else pc+1.
  - JMP 0111: pc=addr.
  - JZ 1010: pc=addr if zero=1, else pc+1.
  - JNZ 1011: pc=addr if zero=0, else pc+1.
  - CALL 1000: push pc+1, then pc=addr, stack_level+1.
  - RET 1001: pc=top of stack, stack_level-1.
  - All other codes (ALU, LDA, STO, reserved): pc+1.
- address is loaded with addr on every en cycle while in RUN.
- CALL with stack_level==STACK_DEPTH:
  - no push, pc holds;
  - fault_ovf=1, state goes to FAULT.
- RET with stack_level==0:
  - pc holds;
  - fault_unf=1, state goes to FAULT.
- Stack is LIFO. Push and pop never occur in the same cycle, because one opcode is handled per cycle.
- HALT state:
  - pc and address hold and opcode is ignored.
  - An en cycle with resume=1 gives state=RUN and pc=pc+1, so execution continues after the HLT.
- FAULT state:
  - pc and address hold; fault flags stay set.
  - An en cycle with resume=1 gives state=RUN, stack_level=0, flags cleared, pc unchanged, so the faulting instruction re-executes with an empty stack.
- resume while in RUN is ignored.
- Reset mid-operation overrides everything immediately, including a pending push/pop and FAULT.
- Wrap-around cases:
  - pc=2^ADDR_W-1 with default advance gives 0.
  - SKZ taken at 2^ADDR_W-2 gives 0.
  - SKZ taken at 2^ADDR_W-1 gives 1.
  - CALL at the top address pushes 0.

Decomposition:
- Package cpu_pkg holds:
  - 4-bit opcode localparams: OP_HLT, OP_SKZ, OP_ADD, OP_AND, OP_XOR, OP_LDA, OP_STO, OP_JMP, OP_CALL, OP_RET, OP_JZ, OP_JNZ;
  - 2-bit state encoding: ST_RUN, ST_HALT, ST_FAULT.
- Sub-module ret_stack (parametrised LIFO):
  - inputs: push, pop, clear, wdata;
  - outputs: top, level, full, empty.
- The top level contains the next-pc mux, FSM and fault flags.

Test Plan:
1. Reset then 33 en cycles of OP_ADD (ADDR_W=5) -> pc counts 0..31, wraps to 0, then reads 1. state=RUN throughout.
2. pc=5, SKZ with zero=1 -> pc=7; pc=7, SKZ with zero=0 -> pc=8. pc=30, SKZ with zero=1 -> pc=0.
3. Nested calls:
   - Sequence: pc=3 CALL 10; CALL 20; RET; RET.
   - pc goes 10, 20, 11, 4.
   - stack_level goes 1, 2, 1, 0.
4. Overflow:
   - Five CALLs to addr 6 with STACK_DEPTH=4.
   - After the 5th: fault_ovf=1, state=FAULT, pc=6, stack_level=4.
   - resume -> state=RUN, stack_level=0, flags 0, pc=6.
5. Halt and underflow:
   - HLT at pc=9: pc stays 9 for 3 en cycles; resume -> pc=10.
   - RET at stack_level=0: fault_unf=1, state=FAULT.
6. Async reset mid-stream:
   - Condition: stack_level=2, pc=17.
   - Action: assert reset between clock edges.
   - Required: pc=0, stack_level=0, state=RUN immediately; en=0 cycles hold all outputs.
